exu_bjp_resolve: RTL and testbench

EXU_BJP_RESOLVE -- requirements
Module: exu_bjp_resolve

---
 rtl/exu_bjp_resolve.sv | 159 +++++++++++++++
 tb/tb_exu_bjp_resolve.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_bjp_resolve.sv
// exu_bjp_resolve: resolves branch/jump direction and target,
// compares against the IFU prediction and raises a redirect on mispredict.
module exu_bjp_resolve #(
    parameter int PC_SIZE = 32,
    parameter int XLEN    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [PC_SIZE-1:0] i_pc,
    input  logic               i_jal,
    input  logic               i_jalr,
    input  logic               i_bxx,
    input  logic [2:0]         i_bxx_op,
    input  logic [XLEN-1:0]    i_rs1,
    input  logic [XLEN-1:0]    i_rs2,
    input  logic [XLEN-1:0]    i_imm,
    input  logic               i_prdt_taken,
    input  logic [PC_SIZE-1:0] i_prdt_pc,
    output logic               flush_req,
    input  logic               flush_ack,
    output logic [PC_SIZE-1:0] flush_pc,
    output logic [31:0]        perf_bjp_cnt,
    output logic [31:0]        perf_mispred_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state;

    logic               accept;
    logic               is_jal;
    logic               is_jalr;
    logic               is_bxx;
    logic               has_cls;
    logic               op_eq;
    logic               op_lt;
    logic               op_ltu;
    logic               bxx_taken;
    logic               act_taken;
    logic               mispred;
    logic [XLEN-1:0]    jalr_sum;
    logic [PC_SIZE-1:0] pc_imm;
    logic [PC_SIZE-1:0] jalr_tgt;
    logic [PC_SIZE-1:0] pc_plus4;
    logic [PC_SIZE-1:0] target;
    logic [PC_SIZE-1:0] redirect_pc;

    assign i_ready = (state == IDLE);
    assign accept  = i_valid & i_ready;

    // Priority jal > jalr > bxx, made one-hot here.
    assign is_jal  = i_jal;
    assign is_jalr = ~i_jal & i_jalr;
    assign is_bxx  = ~i_jal & ~i_jalr & i_bxx;
    assign has_cls = i_jal | i_jalr | i_bxx;

    assign op_eq  = (i_rs1 == i_rs2);
    assign op_lt  = ($signed(i_rs1) < $signed(i_rs2));
    assign op_ltu = (i_rs1 < i_rs2);

    assign pc_imm   = i_pc + i_imm[PC_SIZE-1:0];
    assign jalr_sum = i_rs1 + i_imm;
    assign jalr_tgt = jalr_sum[PC_SIZE-1:0] & ~PC_SIZE'(1);
    assign pc_plus4 = i_pc + PC_SIZE'(4);

    // Branch condition decode by funct3; reserved encodings never take.
    always_comb begin
        bxx_taken = 1'b0;
        case (i_bxx_op)
            3'b000:  bxx_taken = op_eq;
            3'b001:  bxx_taken = ~op_eq;
            3'b100:  bxx_taken = op_lt;
            3'b101:  bxx_taken = ~op_lt;
            3'b110:  bxx_taken = op_ltu;
            3'b111:  bxx_taken = ~op_ltu;
            default: bxx_taken = 1'b0;
        endcase
    end

    // Actual direction and target for the winning class.
    always_comb begin
        act_taken = 1'b0;
        target    = pc_imm;
        unique case (1'b1)
            is_jal: begin
                act_taken = 1'b1;
                target    = pc_imm;
            end
            is_jalr: begin
                act_taken = 1'b1;
                target    = jalr_tgt;
            end
            is_bxx: begin
                act_taken = bxx_taken;
                target    = pc_imm;
            end
            default: begin
                act_taken = 1'b0;
                target    = pc_imm;
            end
        endcase
    end

    // Beats with no class set are never mispredicts.
    assign mispred = has_cls &
                     ((act_taken != i_prdt_taken) |
                      (act_taken & i_prdt_taken &
                       (target != i_prdt_pc)));

    assign redirect_pc = act_taken ? target : pc_plus4;

    // Redirect FSM: flush_req/flush_pc held until the IFU acks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flush_req <= 1'b0;
            flush_pc  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept & mispred) begin
                        state     <= FLUSH;
                        flush_req <= 1'b1;
                        flush_pc  <= redirect_pc;
                    end
                end
                FLUSH: begin
                    if (flush_ack) begin
                        state     <= IDLE;
                        flush_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    flush_req <= 1'b0;
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bjp_cnt     <= '0;
            perf_mispred_cnt <= '0;
        end else begin
            if (accept & has_cls & (perf_bjp_cnt != '1))
                perf_bjp_cnt <= perf_bjp_cnt + 32'd1;
            if (accept & mispred & (perf_mispred_cnt != '1))
                perf_mispred_cnt <= perf_mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_exu_bjp_resolve.sv
// tb_exu_bjp_resolve: directed + random stimulus, reference model
// feeding a per-cycle expectation queue drained by a monitor.
module tb_exu_bjp_resolve;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_pc;
    logic        i_jal;
    logic        i_jalr;
    logic        i_bxx;
    logic [2:0]  i_bxx_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic [31:0] i_imm;
    logic        i_prdt_taken;
    logic [31:0] i_prdt_pc;
    logic        flush_req;
    logic        flush_ack;
    logic [31:0] flush_pc;
    logic [31:0] perf_bjp_cnt;
    logic [31:0] perf_mispred_cnt;

    exu_bjp_resolve #(.PC_SIZE(32), .XLEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_valid          (i_valid),
        .i_ready          (i_ready),
        .i_pc             (i_pc),
        .i_jal            (i_jal),
        .i_jalr           (i_jalr),
        .i_bxx            (i_bxx),
        .i_bxx_op         (i_bxx_op),
        .i_rs1            (i_rs1),
        .i_rs2            (i_rs2),
        .i_imm            (i_imm),
        .i_prdt_taken     (i_prdt_taken),
        .i_prdt_pc        (i_prdt_pc),
        .flush_req        (flush_req),
        .flush_ack        (flush_ack),
        .flush_pc         (flush_pc),
        .perf_bjp_cnt     (perf_bjp_cnt),
        .perf_mispred_cnt (perf_mispred_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic        jal;
        logic        jalr;
        logic        bxx;
        logic [2:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        pt;
        logic [31:0] ppc;
    } beat_t;

    typedef struct {
        logic        fr;
        logic [31:0] fpc;
        logic        rdy;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t q[$];

    int tests  = 0;
    int failed = 0;

    bit          m_flush = 0;
    logic [31:0] m_fpc   = 0;
    logic [31:0] m_bc    = 0;
    logic [31:0] m_mc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    // Architectural meaning of a branch/jump, straight from the ISA rules.
    function automatic void ref_resolve(input beat_t b, output bit cls,
                                        output bit tk,
                                        output logic [31:0] tgt);
        longint s1;
        longint s2;
        s1  = longint'($signed(b.rs1));
        s2  = longint'($signed(b.rs2));
        cls = b.jal | b.jalr | b.bxx;
        tk  = 0;
        tgt = b.pc + b.imm;
        if (b.jal) begin
            tk = 1;
        end else if (b.jalr) begin
            tk  = 1;
            tgt = (b.rs1 + b.imm) & 32'hFFFF_FFFE;
        end else if (b.bxx) begin
            case (b.op)
                3'd0: tk = (b.rs1 == b.rs2);
                3'd1: tk = (b.rs1 != b.rs2);
                3'd4: tk = (s1 < s2);
                3'd5: tk = (s1 >= s2);
                3'd6: tk = (b.rs1 < b.rs2);
                3'd7: tk = (b.rs1 >= b.rs2);
                default: tk = 0;
            endcase
        end
    endfunction

    function automatic beat_t mk(input logic [31:0] pc, input logic jal,
                                 input logic jalr, input logic bxx,
                                 input logic [2:0] op,
                                 input logic [31:0] rs1,
                                 input logic [31:0] rs2,
                                 input logic [31:0] imm,
                                 input logic pt, input logic [31:0] ppc);
        beat_t b;
        b.pc = pc; b.jal = jal; b.jalr = jalr; b.bxx = bxx; b.op = op;
        b.rs1 = rs1; b.rs2 = rs2; b.imm = imm; b.pt = pt; b.ppc = ppc;
        return b;
    endfunction

    // One clock of stimulus; the model predicts the post-edge outputs.
    task automatic cyc(input logic r, input logic v, input logic ack,
                       input beat_t b);
        bit          cls;
        bit          tk;
        logic [31:0] tgt;
        exp_t        e;
        @(negedge clk);
        rst = r; i_valid = v; flush_ack = ack;
        i_pc = b.pc; i_jal = b.jal; i_jalr = b.jalr; i_bxx = b.bxx;
        i_bxx_op = b.op; i_rs1 = b.rs1; i_rs2 = b.rs2; i_imm = b.imm;
        i_prdt_taken = b.pt; i_prdt_pc = b.ppc;
        if (r) begin
            m_flush = 0; m_fpc = 0; m_bc = 0; m_mc = 0;
        end else if (m_flush) begin
            if (ack) m_flush = 0;
        end else if (v) begin
            ref_resolve(b, cls, tk, tgt);
            if (cls) begin
                if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
                if (tk != b.pt || (tk && tgt != b.ppc)) begin
                    if (m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
                    m_fpc   = tk ? tgt : b.pc + 4;
                    m_flush = 1;
                end
            end
        end
        e.fr = m_flush; e.fpc = m_fpc; e.rdy = !m_flush;
        e.bc = m_bc; e.mc = m_mc;
        q.push_back(e);
    endtask

    function automatic logic [31:0] pick_rs();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'd5;
            3: return 32'hFFFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    function automatic beat_t rnd_beat();
        beat_t       b;
        bit          cls;
        bit          tk;
        logic [31:0] tgt;
        b.pc   = $urandom();
        b.jal  = ($urandom_range(0, 5) == 0);
        b.jalr = ($urandom_range(0, 4) == 0);
        b.bxx  = ($urandom_range(0, 9) < 7);
        b.op   = 3'($urandom_range(0, 7));
        b.rs1  = pick_rs();
        b.rs2  = ($urandom_range(0, 3) == 0) ? b.rs1 : pick_rs();
        b.imm  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 64))
                                            : $urandom();
        ref_resolve(b, cls, tk, tgt);
        b.pt  = ($urandom_range(0, 3) == 0) ? !tk : tk;
        case ($urandom_range(0, 3))
            0: b.ppc = $urandom();
            1: b.ppc = tgt ^ 32'h4;
            default: b.ppc = tgt;
        endcase
        return b;
    endfunction

    // Monitor: compares every cycle's outputs against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("flush_req", 32'(flush_req), 32'(e.fr));
                chk("flush_pc", flush_pc, e.fpc);
                chk("i_ready", 32'(i_ready), 32'(e.rdy));
                chk("perf_bjp_cnt", perf_bjp_cnt, e.bc);
                chk("perf_mispred_cnt", perf_mispred_cnt, e.mc);
            end
        end
    end

    initial begin
        beat_t nb;
        beat_t b;
        nb = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1; i_valid = 0; flush_ack = 0;
        i_pc = 0; i_jal = 0; i_jalr = 0; i_bxx = 0; i_bxx_op = 0;
        i_rs1 = 0; i_rs2 = 0; i_imm = 0; i_prdt_taken = 0; i_prdt_pc = 0;

        cyc(1, 0, 0, nb);
        cyc(1, 0, 0, nb);

        // BEQ taken, predicted not taken
        b = mk(32'h8000_0000, 0, 0, 1, 3'b000, 5, 5, 32'h10, 0, 0);
        cyc(0, 1, 0, b);
        cyc(0, 0, 1, nb);

        // BLTU not taken (correct), then BLT taken (mispredict)
        b = mk(32'h100, 0, 0, 1, 3'b110, 32'hFFFF_FFFF, 1, 32'h20, 0, 0);
        cyc(0, 1, 0, b);
        b.op = 3'b100;
        cyc(0, 1, 0, b);
        cyc(0, 0, 1, nb);

        // JALR bit-0 clear: matching then mismatching prediction
        b = mk(32'h40, 0, 1, 0, 0, 32'h8000_1003, 0, 0, 1, 32'h8000_1002);
        cyc(0, 1, 0, b);
        b.ppc = 32'h8000_1000;
        cyc(0, 1, 0, b);

        // Hold the redirect 5 cycles with i_valid high, then ack
        b = mk(32'h200, 1, 0, 0, 0, 0, 0, 32'h8, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, b);
        cyc(0, 1, 1, b);
        cyc(0, 0, 1, nb);

        // Reset during FLUSH, then jal wraps around
        b = mk(32'h300, 0, 0, 1, 3'b001, 1, 2, 32'h40, 0, 0);
        cyc(0, 1, 0, b);
        cyc(1, 0, 0, nb);
        b = mk(32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0, 32'h8, 0, 0);
        cyc(0, 1, 0, b);
        cyc(0, 0, 1, nb);

        // Back-to-back correct predictions, and a no-class beat
        b = mk(32'h1000, 1, 1, 1, 0, 0, 0, 32'h20, 1, 32'h1020);
        cyc(0, 1, 0, b);
        cyc(0, 1, 0, b);
        b = mk(32'h1000, 0, 0, 0, 0, 0, 0, 32'h20, 1, 32'h9);
        cyc(0, 1, 1, b);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) == 0), rnd_beat());
        end

        cyc(0, 0, 1, nb);
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
